// File: rtl/exu_bjp_if.sv
// exu_bjp_if: request, result and redirect bundle of the branch/jump unit; BJP_BHT_EN adds the BHT lookup pair
interface exu_bjp_if #(parameter int XLEN = 32);
  logic            valid, ready;
  logic [7:0]      op;
  logic [XLEN-1:0] rs1, rs2, imm, pc, pred_addr;
  logic            pred_taken;
  logic            res_valid, taken, misalign, flush;
  logic [XLEN-1:0] target, link;
  logic            redir_valid, redir_ready;
  logic [XLEN-1:0] redir_addr;
`ifdef BJP_BHT_EN
  logic [XLEN-1:0] bht_pc;
  logic            bht_taken;
  modport master (
    output valid, op, rs1, rs2, imm, pc, pred_taken, pred_addr, redir_ready, bht_pc,
    input  ready, res_valid, taken, target, link, misalign, flush, redir_valid, redir_addr, bht_taken
  );
  modport slave (
    input  valid, op, rs1, rs2, imm, pc, pred_taken, pred_addr, redir_ready, bht_pc,
    output ready, res_valid, taken, target, link, misalign, flush, redir_valid, redir_addr, bht_taken
  );
`else
  modport master (
    output valid, op, rs1, rs2, imm, pc, pred_taken, pred_addr, redir_ready,
    input  ready, res_valid, taken, target, link, misalign, flush, redir_valid, redir_addr
  );
  modport slave (
    input  valid, op, rs1, rs2, imm, pc, pred_taken, pred_addr, redir_ready,
    output ready, res_valid, taken, target, link, misalign, flush, redir_valid, redir_addr
  );
`endif
endinterface

// File: rtl/exu_bjp_unit.sv
// exu_bjp_unit: registered branch/jump resolution with prediction check and IFU redirect; BJP_BHT_EN adds a 2-bit counter BHT
module exu_bjp_unit #(
  parameter int XLEN      = 32,
  parameter int IALIGN    = 32,
  parameter int BHT_IDX_W = 4
) (
  input logic       clk,
  input logic       rst,
  exu_bjp_if.slave  b
);
  typedef enum logic {IDLE, REDIR} state_t;
  state_t state, state_nx;
  logic            accept, jal, jalr, is_cond, eq, slt, ult, taken_c, mis_c, mispred_c;
  logic [XLEN-1:0] jsum, target_c, link_c;
  assign accept    = b.valid & b.ready;
  assign jal       = b.op[7];
  assign jalr      = ~b.op[7] & b.op[6];
  assign is_cond   = ~|b.op[7:6] & |b.op[5:0];
  assign eq        = b.rs1 == b.rs2;
  assign slt       = $signed(b.rs1) < $signed(b.rs2);
  assign ult       = b.rs1 < b.rs2;
  assign taken_c   = (jal | jalr) ? 1'b1 : b.op[5] ? eq : b.op[4] ? ~eq : b.op[3] ? slt :
                     b.op[2] ? ~slt : b.op[1] ? ult : b.op[0] ? ~ult : 1'b0;
  assign jsum      = b.rs1 + b.imm;
  assign target_c  = jalr ? {jsum[XLEN-1:1], 1'b0} : b.pc + b.imm;
  assign link_c    = b.pc + XLEN'(4);
  assign mis_c     = taken_c & ((IALIGN == 32) ? |target_c[1:0] : target_c[0]);
  // Non-branch ops never mispredict, and a misaligned target raises an exception instead of a redirect
  assign mispred_c = |b.op & ~mis_c & ((taken_c != b.pred_taken) | (taken_c & (target_c != b.pred_addr)));
  assign b.ready       = state == IDLE;
  assign b.redir_valid = state == REDIR;
  // State register; reset drops any pending redirect at once
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // Enter REDIR together with the registered mispredict, leave once the IFU takes it
  always_comb begin
    state_nx = (state == IDLE) ? ((accept & mispred_c) ? REDIR : IDLE) : (b.redir_ready ? IDLE : REDIR);
  end
  // Register the resolution one cycle after acceptance; redirect address stays put while in REDIR
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      b.res_valid  <= 1'b0;
      b.flush      <= 1'b0;
      b.taken      <= 1'b0;
      b.target     <= '0;
      b.link       <= '0;
      b.misalign   <= 1'b0;
      b.redir_addr <= '0;
    end else begin
      b.res_valid <= accept;
      b.flush     <= accept & mispred_c;
      if (accept) begin
        b.taken    <= taken_c;
        b.target   <= target_c;
        b.link     <= link_c;
        b.misalign <= mis_c;
      end
      if (accept & mispred_c) b.redir_addr <= taken_c ? target_c : link_c;
    end
`ifdef BJP_BHT_EN
  logic [1:0]           bht [2**BHT_IDX_W];
  logic                 bht_upd;
  logic [BHT_IDX_W-1:0] bht_idx;
  // Train the counter on the result cycle of an aligned conditional branch, saturating at 0 and 3
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bht_upd <= 1'b0;
      bht_idx <= '0;
      for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b01;
    end else begin
      bht_upd <= accept & is_cond & ~mis_c;
      if (accept) bht_idx <= b.pc[BHT_IDX_W+1:2];
      if (bht_upd) bht[bht_idx] <= b.taken ? ((bht[bht_idx] == 2'd3) ? 2'd3 : bht[bht_idx] + 2'd1)
                                           : ((bht[bht_idx] == 2'd0) ? 2'd0 : bht[bht_idx] - 2'd1);
    end
  assign b.bht_taken = bht[b.bht_pc[BHT_IDX_W+1:2]][1];
`endif
endmodule

// File: tb/tb_exu_bjp_unit.sv
// tb_exu_bjp_unit: directed checks of exu_bjp_unit at IALIGN 32 and 16 (BJP_BHT_EN adds BHT checks)
module tb_exu_bjp_unit;
  logic clk, rst;
  int checks = 0, failures = 0;
  exu_bjp_if #(.XLEN(32)) a ();
  exu_bjp_if #(.XLEN(32)) h ();
  exu_bjp_unit #(.XLEN(32), .IALIGN(32), .BHT_IDX_W(4)) dut   (.clk(clk), .rst(rst), .b(a.slave));
  exu_bjp_unit #(.XLEN(32), .IALIGN(16), .BHT_IDX_W(4)) dut16 (.clk(clk), .rst(rst), .b(h.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [7:0] op, input logic [31:0] rs1, rs2, imm, pc,
                     input logic pt, input logic [31:0] pa);
    a.valid = 1'b1; a.op = op; a.rs1 = rs1; a.rs2 = rs2; a.imm = imm; a.pc = pc; a.pred_taken = pt; a.pred_addr = pa;
    h.valid = 1'b1; h.op = op; h.rs1 = rs1; h.rs2 = rs2; h.imm = imm; h.pc = pc; h.pred_taken = pt; h.pred_addr = pa;
  endtask
  task automatic idle();
    a.valid = 1'b0;
    h.valid = 1'b0;
  endtask
  task automatic rdy(input logic r);
    a.redir_ready = r;
    h.redir_ready = r;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    req(8'h00, 0, 0, 0, 0, 1'b0, 0);
    idle();
    rdy(1'b0);
`ifdef BJP_BHT_EN
    a.bht_pc = 32'h40;
    h.bht_pc = 32'h40;
`endif
    #1;
    chk("rst_ready", a.ready, 1);
    chk("rst_res_valid", a.res_valid, 0);
    chk("rst_redir_valid", a.redir_valid, 0);
    chk("rst_flush", a.flush, 0);
    chk("rst_target", a.target, 0);
    chk("rst_redir_addr", a.redir_addr, 0);
    tick();
    rst = 1'b0;
    tick();
    req(8'h20, 5, 5, 32'h20, 32'h100, 1'b1, 32'h120);
    tick();
    chk("beq_res_valid", a.res_valid, 1);
    chk("beq_taken", a.taken, 1);
    chk("beq_target", a.target, 32'h120);
    chk("beq_link", a.link, 32'h104);
    chk("beq_flush", a.flush, 0);
    chk("beq_redir_valid", a.redir_valid, 0);
    chk("beq_ready", a.ready, 1);
    req(8'h10, 5, 5, 32'h20, 32'h100, 1'b0, 0);
    tick();
    chk("bne_nt_res_valid", a.res_valid, 1);
    chk("bne_nt_taken", a.taken, 0);
    chk("bne_nt_flush", a.flush, 0);
    req(8'h02, 1, 32'hFFFFFFFF, 32'h20, 32'h100, 1'b1, 32'h120);
    tick();
    chk("bltu_taken", a.taken, 1);
    chk("bltu_flush", a.flush, 0);
    req(8'h04, 32'hFFFFFFFF, 1, 32'h20, 32'h100, 1'b0, 0);
    tick();
    chk("bge_taken", a.taken, 0);
    chk("bge_flush", a.flush, 0);
    req(8'h00, 0, 0, 32'h20, 32'h100, 1'b1, 32'h120);
    tick();
    chk("nop_res_valid", a.res_valid, 1);
    chk("nop_taken", a.taken, 0);
    chk("nop_flush", a.flush, 0);
    req(8'h21, 2, 1, 32'h20, 32'h100, 1'b0, 0);
    tick();
    chk("multi_taken", a.taken, 0);
    chk("multi_flush", a.flush, 0);
    idle();
    rdy(1'b1);
    tick();
    chk("idle_res_valid", a.res_valid, 0);
    chk("idle_ready", a.ready, 1);
    chk("idle_redir_valid", a.redir_valid, 0);
    rdy(1'b0);
    req(8'h08, 32'hFFFFFFFF, 1, 32'h40, 32'h300, 1'b0, 0);
    tick();
    chk("blt_res_valid", a.res_valid, 1);
    chk("blt_taken", a.taken, 1);
    chk("blt_flush", a.flush, 1);
    chk("blt_redir_valid", a.redir_valid, 1);
    chk("blt_redir_addr", a.redir_addr, 32'h340);
    chk("blt_ready", a.ready, 0);
    req(8'h20, 5, 5, 32'h20, 32'h100, 1'b1, 32'h120);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_flush", a.flush, 0);
      chk("hold_redir_valid", a.redir_valid, 1);
      chk("hold_redir_addr", a.redir_addr, 32'h340);
      chk("hold_ready", a.ready, 0);
      chk("hold_res_valid", a.res_valid, 0);
    end
    idle();
    rdy(1'b1);
    tick();
    chk("release_redir_valid", a.redir_valid, 0);
    chk("release_ready", a.ready, 1);
    chk("release_res_valid", a.res_valid, 0);
    rdy(1'b0);
    req(8'h40, 32'h1003, 0, 0, 32'h200, 1'b1, 32'h1002);
    tick();
    chk("jalr16_target", h.target, 32'h1002);
    chk("jalr16_link", h.link, 32'h204);
    chk("jalr16_taken", h.taken, 1);
    chk("jalr16_flush", h.flush, 0);
    chk("jalr16_misalign", h.misalign, 0);
    chk("jalr32_misalign", a.misalign, 1);
    chk("jalr32_flush", a.flush, 0);
    req(8'h40, 32'h1003, 0, 0, 32'h200, 1'b1, 32'h2000);
    tick();
    chk("jalr16_mp_flush", h.flush, 1);
    chk("jalr16_mp_redir_valid", h.redir_valid, 1);
    chk("jalr16_mp_redir_addr", h.redir_addr, 32'h1002);
    chk("jalr32_mp_redir_valid", a.redir_valid, 0);
    chk("jalr32_mp_ready", a.ready, 1);
    idle();
    rdy(1'b1);
    tick();
    chk("jalr16_release_ready", h.ready, 1);
    rdy(1'b0);
    req(8'h80, 0, 0, 32'h6, 32'h100, 1'b1, 32'h106);
    tick();
    chk("jal32_misalign", a.misalign, 1);
    chk("jal32_taken", a.taken, 1);
    chk("jal32_flush", a.flush, 0);
    chk("jal32_redir_valid", a.redir_valid, 0);
    chk("jal32_res_valid", a.res_valid, 1);
    chk("jal16_misalign", h.misalign, 0);
    chk("jal16_flush", h.flush, 0);
    chk("jal16_target", h.target, 32'h106);
    req(8'h80, 0, 0, 32'h8, 32'hFFFFFFFC, 1'b1, 32'h4);
    tick();
    chk("wrap_target", a.target, 32'h4);
    chk("wrap_link", a.link, 32'h0);
    chk("wrap_flush", a.flush, 0);
    chk("wrap_misalign", a.misalign, 0);
    req(8'h10, 7, 7, 32'h100, 32'h400, 1'b1, 32'h500);
    rdy(1'b1);
    tick();
    chk("nt_mp_taken", a.taken, 0);
    chk("nt_mp_flush", a.flush, 1);
    chk("nt_mp_redir_valid", a.redir_valid, 1);
    chk("nt_mp_redir_addr", a.redir_addr, 32'h404);
    idle();
    tick();
    chk("first_cycle_redir_valid", a.redir_valid, 0);
    chk("first_cycle_ready", a.ready, 1);
    chk("first_cycle_flush", a.flush, 0);
    rdy(1'b0);
    req(8'h08, 32'hFFFFFFFF, 1, 32'h40, 32'h300, 1'b0, 0);
    tick();
    idle();
    chk("pre_rst_redir_valid", a.redir_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_redir_valid", a.redir_valid, 0);
    chk("mid_rst_flush", a.flush, 0);
    chk("mid_rst_res_valid", a.res_valid, 0);
    chk("mid_rst_taken", a.taken, 0);
    chk("mid_rst_target", a.target, 0);
    chk("mid_rst_redir_addr", a.redir_addr, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", a.ready, 1);
    chk("post_rst_redir_valid", a.redir_valid, 0);
`ifdef BJP_BHT_EN
    chk("bht_reset", a.bht_taken, 0);
    req(8'h10, 1, 2, 32'h10, 32'h40, 1'b1, 32'h50);
    tick();
    chk("bht_t1_preupdate", a.bht_taken, 0);
    tick();
    chk("bht_t2", a.bht_taken, 1);
    tick();
    chk("bht_t3", a.bht_taken, 1);
    idle();
    tick();
    chk("bht_sat", a.bht_taken, 1);
    req(8'h10, 3, 3, 32'h10, 32'h40, 1'b0, 0);
    tick();
    chk("bht_n1", a.bht_taken, 1);
    tick();
    chk("bht_n2", a.bht_taken, 1);
    idle();
    tick();
    chk("bht_n_final", a.bht_taken, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
